// File: rtl/iter_alu_pkg.sv
// rtl/iter_alu_pkg.sv - shared op/state encodings and default sizing for iter_alu
//
// Contents:
//   DEF_WIDTH / DEF_SHW : default word width and shift-amount width
//   op_e                : 3-bit operation code (AND..MULTU)
//   state_e             : control state of the iterative ALU
package iter_alu_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_SLT   = 3'd4,
        OP_SLL   = 3'd5,
        OP_SRL   = 3'd6,
        OP_MULTU = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_word.sv
// rtl/alu_word.sv - combinational word-wide AND/OR/add-sub/SLT/shift unit
//
// Ports:
//   op       in   operation code (MULTU yields zeros here; it is iterated in the top)
//   a, b     in   WIDTH-bit operands
//   shamt    in   SHW-bit shift amount for SLL/SRL (shifts b)
//   result   out  WIDTH-bit result
//   overflow out  signed overflow, ADD/SUB only
//   cout     out  carry out of the MSB, ADD/SUB only
module alu_word
    import iter_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             cout
);

    logic             subtract;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             sum_ovf;
    logic             shift_oob;

    // SUB and SLT share the adder as a + ~b + 1.
    assign subtract = (op == OP_SUB) || (op == OP_SLT);
    assign b_eff    = subtract ? ~b : b;
    assign sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, subtract};
    assign sum_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    // WIDTH always fits in SHW+1 bits because 2**SHW >= WIDTH.
    assign shift_oob = {1'b0, shamt} >= (SHW+1)'(WIDTH);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        cout     = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD, OP_SUB: begin
                result   = sum[WIDTH-1:0];
                overflow = sum_ovf;
                cout     = sum[WIDTH];
            end
            OP_SLT: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sum_ovf};
            OP_SLL: result = shift_oob ? '0 : (b << shamt);
            OP_SRL: result = shift_oob ? '0 : (b >> shamt);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - multi-cycle ALU with valid/ready handshake and shift-add MULTU
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous cancel of in-flight op and pending result
//   in_valid/in_ready     request handshake; op, a, b, shamt sampled on accept
//   out_valid/out_ready   result handshake; outputs held while out_ready=0
//   result, result_hi     result word; result_hi is the MULTU high word, else 0
//   zero, overflow, cout  registered flags of the presented result
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state, state_next;
    op_e              op_in;
    logic             accept;
    logic             mul_last;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] mcand;
    // The 2*WIDTH accumulator is {acc_hi, mplier}: the multiplier bits are
    // shifted out of the low half as product bits are shifted in.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_lo_next;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic             alu_cout;

    assign op_in     = op_e'(op);
    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state == ST_DONE);
    assign mul_last  = (counter == CW'(WIDTH - 1));

    assign mul_sum     = {1'b0, acc_hi} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    assign mul_lo_next = {mul_sum[0], mplier[WIDTH-1:1]};

    alu_word #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_alu_word (
        .op       (op_in),
        .a        (a),
        .b        (b),
        .shamt    (shamt),
        .result   (alu_result),
        .overflow (alu_overflow),
        .cout     (alu_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_next = (op_in == OP_MULTU) ? ST_MUL : ST_DONE;
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (accept) begin
                        state_next = (op_in == OP_MULTU) ? ST_MUL : ST_DONE;
                    end else if (out_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter   <= '0;
            mcand     <= '0;
            acc_hi    <= '0;
            mplier    <= '0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            cout      <= 1'b0;
        end else if (flush) begin
            counter <= '0;
        end else if (accept) begin
            if (op_in == OP_MULTU) begin
                mcand   <= a;
                mplier  <= b;
                acc_hi  <= '0;
                counter <= '0;
            end else begin
                result    <= alu_result;
                result_hi <= '0;
                zero      <= (alu_result == '0);
                overflow  <= alu_overflow;
                cout      <= alu_cout;
            end
        end else if (state == ST_MUL) begin
            acc_hi  <= mul_sum[WIDTH:1];
            mplier  <= mul_lo_next;
            counter <= counter + CW'(1);
            // Publish only on the final step so no partial product is ever visible.
            if (mul_last) begin
                result    <= mul_lo_next;
                result_hi <= mul_sum[WIDTH:1];
                zero      <= ({mul_sum[WIDTH:1], mul_lo_next} == '0);
                overflow  <= 1'b0;
                cout      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - self-checking bench for iter_alu against an arithmetic reference model
module tb_iter_alu;
    import iter_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        overflow;
    logic        cout;

    int checks = 0;
    int errors = 0;

    iter_alu #(.WIDTH(32), .SHW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .overflow  (overflow),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural meaning of each op.
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic [4:0] s, output logic [31:0] r, output logic [31:0] hi,
                                  output logic ov, output logic co);
        longint sx;
        longint sy;
        longint t;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = 0; hi = 0; ov = 0; co = 0;
        case (o)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: begin
                t  = sx + sy;
                r  = x + y;
                co = (64'(x) + 64'(y)) > 64'hFFFF_FFFF;
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd3: begin
                t  = sx - sy;
                r  = x - y;
                co = (x >= y);
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd4: r = (sx < sy) ? 32'd1 : 32'd0;
            3'd5: r = (int'(s) >= 32) ? 32'd0 : (y << s);
            3'd6: r = (int'(s) >= 32) ? 32'd0 : (y >> s);
            default: begin
                p  = 64'(x) * 64'(y);
                r  = p[31:0];
                hi = p[63:32];
            end
        endcase
    endfunction

    task automatic send_and_check(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                                  input logic [4:0] sh, input string tag);
        logic [31:0] er;
        logic [31:0] eh;
        logic        eo;
        logic        ec;
        int          cyc;
        int          rdy_hi;
        model(o, av, bv, sh, er, eh, eo, ec);
        @(negedge clk);
        op = o; a = av; b = bv; shamt = sh; in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        // Scramble the request lines: only the accepted values may matter.
        in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
        cyc = 1;
        rdy_hi = 0;
        while (!out_valid && cyc < 100) begin
            if (in_ready) rdy_hi++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), (o == 3'd7) ? 64'd33 : 64'd1);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " result"}, 64'(result), 64'(er));
        chk({tag, " result_hi"}, 64'(result_hi), 64'(eh));
        chk({tag, " overflow"}, 64'(overflow), 64'(eo));
        chk({tag, " cout"}, 64'(cout), 64'(ec));
        chk({tag, " zero"}, 64'(zero), 64'({eh, er} == 64'd0));
        if (o == 3'd7) chk({tag, " in_ready low in MUL"}, 64'(rdy_hi), 64'd0);
        @(negedge clk);
        chk({tag, " drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = 3'd0;
        a = '0; b = '0; shamt = '0; out_ready = 1'b1;
        #2;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset result", {result_hi, result}, 64'd0);
        chk("reset flags", {61'd0, zero, overflow, cout}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", 64'(in_ready), 64'd1);

        send_and_check(3'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, "add ovf");

        // SUB then back-to-back SLT with out_ready held high.
        @(negedge clk);
        op = 3'd3; a = 32'd5; b = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("sub result", 64'(result), 64'd0);
        chk("sub flags", {61'd0, zero, cout, overflow}, {61'd0, 3'b110});
        chk("sub in_ready", 64'(in_ready), 64'd1);
        op = 3'd4; a = 32'hFFFF_FFFF; b = 32'd1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("slt b2b valid", 64'(out_valid), 64'd1);
        chk("slt b2b result", 64'(result), 64'd1);
        @(negedge clk);
        chk("slt drain", 64'(out_valid), 64'd0);

        send_and_check(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, "multu max");

        // Backpressure: the result must hold while out_ready is low.
        @(negedge clk);
        op = 3'd2; a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", 64'(out_valid), 64'd1);
            chk("bp result", 64'(result), 64'd7);
            chk("bp in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp release", 64'(out_valid), 64'd0);

        // Flush during MULTU 6x7 after 10 MUL cycles.
        @(negedge clk);
        op = 3'd7; a = 32'd6; b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        chk("mul busy before flush", 64'(in_ready), 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush out_valid", 64'(out_valid), 64'd0);
        chk("flush in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        chk("flush no result", 64'(seen), 64'd0);

        // Flush overrides a simultaneous accept.
        op = 3'd1; a = 32'h1; b = 32'h2; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush beats accept", 64'(out_valid), 64'd0);

        send_and_check(3'd1, 32'hF0, 32'h0F, 5'd0, "or after flush");

        // Async reset pulse in the middle of a MULTU.
        @(negedge clk);
        op = 3'd7; a = 32'hDEAD_BEEF; b = 32'h1234_5678; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-mul reset valid", 64'(out_valid), 64'd0);
        chk("mid-mul reset result", {result_hi, result}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        chk("no partial product", 64'(seen), 64'd0);

        send_and_check(3'd5, 32'd1, 32'd1, 5'd31, "sll 31");
        send_and_check(3'd6, 32'd0, 32'h8000_0000, 5'd31, "srl 31");
        send_and_check(3'd3, 32'h8000_0000, 32'd1, 5'd0, "sub ovf");
        send_and_check(3'd4, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0, "slt ovf case");

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if ((i % 7) == 0) ra = 32'h8000_0000;
            if ((i % 5) == 0) rb = ra;
            send_and_check(3'($urandom_range(0, 7)), ra, rb, 5'($urandom), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
